vc_flow_tx: RTL and testbench
=============================

// Module: vc_flow_tx
// PURPOSE
//  Flow-controlled per-port transmitter that drives one switch ingress port (data_pX/valid_pX).
//  Buffers 5-bit payloads in two virtual-channel FIFOs (VC0, VC1) and arbitrates between them.
//  Emits BUS_SIZE+1-bit words with the VC number in the MSB.
//  Obeys the per-VC pause/continue flow control returned by the switch.
// PARAMETERS
//  BUS_SIZE    5                 payload width; output word is BUS_SIZE+1 bits
//  ADDR_WIDTH  2                 FIFO address width per VC
//  MEM_LENGTH  1<<ADDR_WIDTH     entries per VC FIFO
// PORTS
//  clk           in   1           single clock; all state updates on posedge
//  reset         in   1           synchronous, active-high
//  wr_data_vc0   in   BUS_SIZE    payload to enqueue on VC0
//  wr_en_vc0     in   1           enqueue strobe VC0
//  wr_data_vc1   in   BUS_SIZE    payload to enqueue on VC1
//  wr_en_vc1     in   1           enqueue strobe VC1
//  pause_vc0     in   1           switch asks to stop VC0
//  continue_vc0  in   1           switch allows VC0 again
//  pause_vc1     in   1           switch asks to stop VC1
//  continue_vc1  in   1           switch allows VC1 again
//  full_vc0      out  1           VC0 FIFO holds MEM_LENGTH entries
//  full_vc1      out  1           VC1 FIFO holds MEM_LENGTH entries
//  data_out      out  BUS_SIZE+1  {vc, payload}; goes to data_pX
//  valid_out     out  1           data_out valid; goes to valid_pX
//  idle          out  1           both FIFOs empty and valid_out low
//  err           out  1           sticky: write attempted while full
// BEHAVIOUR
//  Reset (sync): FIFO pointers/counts = 0; data_out = 0; valid_out = 0; err = 0.
//   - Both VC gates = RUN; last_grant = VC1, so VC0 is granted first.
//   - full_* = 0 and idle = 1 are combinational from registered state.
//  FIFOs: count is ADDR_WIDTH+1 bits; read and write pointers wrap modulo MEM_LENGTH.
//   - Write when wr_en and !full: data stored at posedge.
//   - Write when full: data dropped, err set to 1 and held until reset.
//     This holds even if the same VC pops on that edge.
//   - Simultaneous push and pop on a non-full VC: count unchanged, both pointers advance.
//  Gate state per VC, one flop:
//   - pause=1 -> PAUSED at the next edge.
//   - continue=1 (pause=0) -> RUN at the next edge.
//   - pause and continue both high -> pause wins.
//  Eligibility per VC: count != 0 && gate == RUN && pause_in == 0.
//   - A pause blocks a pop on the same edge it is sampled.
//   - A continue enables pops only from the following edge.
//  Arbitration: round-robin.
//   - If both VCs are eligible, grant the VC not equal to last_grant.
//   - If only one is eligible, grant it.
//   - last_grant updates only on a grant.
//  Output: registered, one word per cycle.
//   - On a grant: data_out <= {vc, fifo head}, valid_out <= 1, head popped.
//   - No grant: valid_out <= 0; data_out holds its last value.
//  Latency: a word written at edge N can appear on data_out after edge N+1, if eligible and granted.
//  A FIFO write at edge N is not visible to the arbiter until edge N+1; there is no bypass.
//  Reset mid-stream: all queued data is discarded; the first output after reset is valid_out = 0.
// TESTING
//  T1: reset, write 0x1B to VC0 -> after edge N+1: data_out = 6'b011011, valid_out = 1, then valid_out = 0, idle = 1.
//  T2: fill VC0 {0x03,0x1A}, VC1 {0x19,0x0D} together -> output order 0x03 (VC0), 0x39, 0x1A, 0x2D; strict alternation.
//  T3: VC0 holds 3 words, pulse pause_vc0 -> no VC0 word from that edge.
//      Pulse continue_vc0 5 cycles later -> VC0 resumes one edge after continue, order intact.
//  T4: write 5 words to VC1 with ADDR_WIDTH = 2 and pause_vc1 held -> full_vc1 = 1 after the 4th write.
//      5th write dropped and err = 1; after continue, exactly 4 words come out.
//  T5: pause_vc0 and continue_vc0 high on the same edge -> VC0 ends PAUSED and emits nothing.
//  T6: assert reset while both FIFOs are non-empty -> next cycle valid_out = 0, idle = 1, err = 0.
//      Pointer wrap: after 3 full fill/drain rounds, payloads still come out in order.

Source files
------------

// File: rtl/vc_flow_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : vc_flow_tx_if
//  Description : Bus bundle between a two-VC transmitter and its user/switch:
//                enqueue strobes, per-VC pause/continue, output word, status.
//  Revision    : 1.0  initial release
// ============================================================================
interface vc_flow_tx_if #(
  parameter int BUS_SIZE = 5
) ();

  logic [BUS_SIZE-1:0] wr_data_vc0;
  logic                wr_en_vc0;
  logic [BUS_SIZE-1:0] wr_data_vc1;
  logic                wr_en_vc1;
  logic                pause_vc0;
  logic                continue_vc0;
  logic                pause_vc1;
  logic                continue_vc1;
  logic                full_vc0;
  logic                full_vc1;
  logic [BUS_SIZE:0]   data_out;
  logic                valid_out;
  logic                idle;
  logic                err;

  // Transmitter side
  modport slave (
    input  wr_data_vc0, wr_en_vc0, wr_data_vc1, wr_en_vc1,
    input  pause_vc0, continue_vc0, pause_vc1, continue_vc1,
    output full_vc0, full_vc1, data_out, valid_out, idle, err
  );

  // Producer / switch side
  modport master (
    output wr_data_vc0, wr_en_vc0, wr_data_vc1, wr_en_vc1,
    output pause_vc0, continue_vc0, pause_vc1, continue_vc1,
    input  full_vc0, full_vc1, data_out, valid_out, idle, err
  );

endinterface
`default_nettype wire

// File: rtl/vc_flow_tx.sv
`default_nettype none
// ============================================================================
//  Module      : vc_flow_tx
//  Description : Per-port transmitter with two virtual-channel FIFOs, per-VC
//                pause/continue gating and round-robin arbitration. Emits one
//                registered {vc, payload} word per granted cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module vc_flow_tx #(
  parameter int BUS_SIZE   = 5,
  parameter int ADDR_WIDTH = 2,
  parameter int MEM_LENGTH = 1 << ADDR_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  vc_flow_tx_if.slave  bus
);

  localparam int NVC = 2;
  localparam logic [ADDR_WIDTH:0] C_FULL_CNT = (ADDR_WIDTH + 1)'(MEM_LENGTH);

  typedef enum logic [0:0] {
    GATE_RUN    = 1'b0,
    GATE_PAUSED = 1'b1
  } gate_e;

  // --------------------------------------------------------------------------
  // Per-VC views of the interface inputs
  // --------------------------------------------------------------------------
  logic [BUS_SIZE-1:0] w_wr_data [NVC];
  logic [NVC-1:0]      w_wr_en;
  logic [NVC-1:0]      w_pause;
  logic [NVC-1:0]      w_cont;

  assign w_wr_data[0] = bus.wr_data_vc0;
  assign w_wr_data[1] = bus.wr_data_vc1;
  assign w_wr_en      = {bus.wr_en_vc1,    bus.wr_en_vc0};
  assign w_pause      = {bus.pause_vc1,    bus.pause_vc0};
  assign w_cont       = {bus.continue_vc1, bus.continue_vc0};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [BUS_SIZE-1:0]   mem_q     [NVC][MEM_LENGTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q  [NVC];
  logic [ADDR_WIDTH-1:0] wr_ptr_d  [NVC];
  logic [ADDR_WIDTH-1:0] rd_ptr_q  [NVC];
  logic [ADDR_WIDTH-1:0] rd_ptr_d  [NVC];
  logic [ADDR_WIDTH:0]   cnt_q     [NVC];
  logic [ADDR_WIDTH:0]   cnt_d     [NVC];
  gate_e                 gate_q    [NVC];
  gate_e                 gate_d    [NVC];
  logic                  last_grant_q;
  logic                  last_grant_d;
  logic [BUS_SIZE:0]     data_out_q;
  logic [BUS_SIZE:0]     data_out_d;
  logic                  valid_out_q;
  logic                  valid_out_d;
  logic                  err_q;
  logic                  err_d;

  // --------------------------------------------------------------------------
  // Combinational status, eligibility and arbitration
  // --------------------------------------------------------------------------
  logic [NVC-1:0] w_full;
  logic [NVC-1:0] w_empty;
  logic [NVC-1:0] w_push;
  logic [NVC-1:0] w_elig;
  logic [NVC-1:0] w_pop;
  logic           w_grant_valid;
  logic           w_grant_vc;

  // Per-VC full/empty, accepted pushes and pop eligibility
  always_comb begin
    for (int v = 0; v < NVC; v++) begin
      w_full[v]  = (cnt_q[v] == C_FULL_CNT);
      w_empty[v] = (cnt_q[v] == '0);
      // A write while full is dropped even if the same VC pops this edge.
      w_push[v]  = w_wr_en[v] & ~w_full[v];
      // A pause sampled on this edge already blocks the pop.
      w_elig[v]  = ~w_empty[v] & (gate_q[v] == GATE_RUN) & ~w_pause[v];
    end
  end

  // Round-robin grant: on contention the VC not granted last time wins
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_vc    = 1'b0;
    w_pop         = '0;
    unique case (w_elig)
      2'b01: begin
        w_grant_valid = 1'b1;
        w_grant_vc    = 1'b0;
      end
      2'b10: begin
        w_grant_valid = 1'b1;
        w_grant_vc    = 1'b1;
      end
      2'b11: begin
        w_grant_valid = 1'b1;
        w_grant_vc    = ~last_grant_q;
      end
      default: begin
        w_grant_valid = 1'b0;
        w_grant_vc    = 1'b0;
      end
    endcase
    if (w_grant_valid) begin
      w_pop[w_grant_vc] = 1'b1;
    end
  end

  // Next-state for FIFO pointers/counts and the pause/run gate of each VC
  always_comb begin
    for (int v = 0; v < NVC; v++) begin
      wr_ptr_d[v] = wr_ptr_q[v] + ADDR_WIDTH'(w_push[v]);
      rd_ptr_d[v] = rd_ptr_q[v] + ADDR_WIDTH'(w_pop[v]);
      cnt_d[v]    = cnt_q[v];
      if (w_push[v] && !w_pop[v]) begin
        cnt_d[v] = cnt_q[v] + 1'b1;
      end else if (!w_push[v] && w_pop[v]) begin
        cnt_d[v] = cnt_q[v] - 1'b1;
      end
      // Pause wins over a simultaneous continue.
      gate_d[v] = gate_q[v];
      if (w_pause[v]) begin
        gate_d[v] = GATE_PAUSED;
      end else if (w_cont[v]) begin
        gate_d[v] = GATE_RUN;
      end
    end
  end

  // Next-state for the output word, grant history and sticky overflow flag
  always_comb begin
    valid_out_d  = w_grant_valid;
    data_out_d   = data_out_q;
    last_grant_d = last_grant_q;
    if (w_grant_valid) begin
      data_out_d   = {w_grant_vc, mem_q[w_grant_vc][rd_ptr_q[w_grant_vc]]};
      last_grant_d = w_grant_vc;
    end
    err_d = err_q | (|(w_wr_en & w_full));
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------

  // Control state; reset discards all queued data and re-arms VC0 first
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NVC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
        gate_q[v]   <= GATE_RUN;
      end
      last_grant_q <= 1'b1;
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      for (int v = 0; v < NVC; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        cnt_q[v]    <= cnt_d[v];
        gate_q[v]   <= gate_d[v];
      end
      last_grant_q <= last_grant_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      err_q        <= err_d;
    end
  end

  // FIFO storage; contents need no reset since counts gate every read
  always_ff @(posedge clk) begin
    for (int v = 0; v < NVC; v++) begin
      if (!reset && w_push[v]) begin
        mem_q[v][wr_ptr_q[v]] <= w_wr_data[v];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.full_vc0  = w_full[0];
  assign bus.full_vc1  = w_full[1];
  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.idle      = w_empty[0] & w_empty[1] & ~valid_out_q;
  assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vc_flow_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vc_flow_tx
//  Description : Directed bench for vc_flow_tx; expected words are queued as
//                stimulus is issued and a negedge monitor compares outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vc_flow_tx;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  vc_flow_tx_if #(.BUS_SIZE(5)) bus ();

  vc_flow_tx #(
    .BUS_SIZE  (5),
    .ADDR_WIDTH(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [5:0] exp_q [$];
  logic [5:0] mon_exp;

  // Scalar comparison, counted
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: every valid word must match the head of the scoreboard
  always @(negedge clk) begin
    if (bus.valid_out !== 1'b0) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got 0x%0h (valid=%b) expected no word", bus.data_out, bus.valid_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.data_out !== mon_exp) begin
          n_err++;
          $display("FAIL sb_word: got 0x%0h expected 0x%0h", bus.data_out, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.wr_data_vc0  = '0;
    bus.wr_en_vc0    = 1'b0;
    bus.wr_data_vc1  = '0;
    bus.wr_en_vc1    = 1'b0;
    bus.pause_vc0    = 1'b0;
    bus.continue_vc0 = 1'b0;
    bus.pause_vc1    = 1'b0;
    bus.continue_vc1 = 1'b0;
  endtask

  task automatic do_reset();
    chk("sb_drained_before_reset", exp_q.size(), 0);
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_data",  bus.data_out,  0);
    chk("rst_idle",  bus.idle,      1);
    chk("rst_full0", bus.full_vc0,  0);
    chk("rst_full1", bus.full_vc1,  0);
    chk("rst_err",   bus.err,       0);
    reset = 1'b0;

    // T1: single word latency
    bus.wr_data_vc0 = 5'h1B;
    bus.wr_en_vc0   = 1'b1;
    exp_q.push_back(6'h1B);
    tick();
    bus.wr_en_vc0 = 1'b0;
    chk("t1_no_bypass", bus.valid_out, 0);
    tick();
    chk("t1_valid", bus.valid_out, 1);
    chk("t1_data",  bus.data_out,  6'h1B);
    tick();
    chk("t1_valid_off", bus.valid_out, 0);
    chk("t1_idle",      bus.idle,      1);
    chk("t1_data_hold", bus.data_out,  6'h1B);

    // T2: round-robin alternation
    do_reset();
    exp_q.push_back(6'h03);
    exp_q.push_back(6'h39);
    exp_q.push_back(6'h1A);
    exp_q.push_back(6'h2D);
    bus.wr_data_vc0 = 5'h03; bus.wr_en_vc0 = 1'b1;
    bus.wr_data_vc1 = 5'h19; bus.wr_en_vc1 = 1'b1;
    tick();
    bus.wr_data_vc0 = 5'h1A;
    bus.wr_data_vc1 = 5'h0D;
    tick();
    clear_inputs();
    for (int i = 0; i < 6; i++) tick();
    chk("t2_idle", bus.idle, 1);

    // T3: pause blocks on its own edge, continue releases one edge later
    do_reset();
    bus.wr_data_vc0 = 5'h05; bus.wr_en_vc0 = 1'b1;
    exp_q.push_back(6'h05);
    tick();
    bus.wr_data_vc0 = 5'h06; bus.pause_vc0 = 1'b1;
    exp_q.push_back(6'h06);
    tick();
    chk("t3_pause_same_edge", bus.valid_out, 0);
    bus.wr_data_vc0 = 5'h07; bus.pause_vc0 = 1'b0;
    exp_q.push_back(6'h07);
    tick();
    chk("t3_paused_a", bus.valid_out, 0);
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_paused", bus.valid_out, 0);
    end
    bus.continue_vc0 = 1'b1;
    tick();
    bus.continue_vc0 = 1'b0;
    chk("t3_cont_edge", bus.valid_out, 0);
    tick();
    chk("t3_resume", bus.valid_out, 1);
    for (int i = 0; i < 3; i++) tick();
    chk("t3_idle", bus.idle, 1);

    // T4: overflow on VC1 while paused
    do_reset();
    bus.pause_vc1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.wr_data_vc1 = 5'(5'h10 + i);
      bus.wr_en_vc1   = 1'b1;
      if (i < 4) exp_q.push_back(6'(6'h30 + i));
      tick();
      if (i < 3) chk("t4_not_full", bus.full_vc1, 0);
      if (i == 3) begin
        chk("t4_full",      bus.full_vc1, 1);
        chk("t4_err_clear", bus.err,      0);
      end
    end
    chk("t4_err_set",    bus.err,      1);
    chk("t4_full_held",  bus.full_vc1, 1);
    chk("t4_held_valid", bus.valid_out, 0);
    clear_inputs();
    bus.continue_vc1 = 1'b1;
    tick();
    bus.continue_vc1 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t4_idle",       bus.idle,     1);
    chk("t4_err_sticky", bus.err,      1);
    chk("t4_drained",    bus.full_vc1, 0);

    // T5: pause and continue together leave VC0 paused
    do_reset();
    bus.wr_data_vc0  = 5'h0F; bus.wr_en_vc0 = 1'b1;
    bus.pause_vc0    = 1'b1;  bus.continue_vc0 = 1'b1;
    tick();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_output", bus.valid_out, 0);
    end
    chk("t5_not_idle", bus.idle, 0);

    // T6: reset mid-stream
    do_reset();
    bus.pause_vc0 = 1'b1;
    bus.pause_vc1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.wr_en_vc0   = 1'b1;
      bus.wr_data_vc0 = (i == 4) ? 5'h1F : 5'(i + 1);
      bus.wr_en_vc1   = (i < 2);
      bus.wr_data_vc1 = 5'(5'h11 + i);
      tick();
    end
    chk("t6_err_set", bus.err, 1);
    clear_inputs();
    bus.continue_vc0 = 1'b1;
    bus.continue_vc1 = 1'b1;
    tick();
    bus.continue_vc0 = 1'b0;
    bus.continue_vc1 = 1'b0;
    exp_q.push_back(6'h01);
    tick();
    chk("t6_first_word", bus.valid_out, 1);
    reset = 1'b1;
    tick();
    chk("t6_rst_valid", bus.valid_out, 0);
    chk("t6_rst_idle",  bus.idle,      1);
    chk("t6_rst_err",   bus.err,       0);
    chk("t6_rst_full0", bus.full_vc0,  0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t6_discarded", bus.idle, 1);

    // Pointer wrap: offset by one word, then three fill/drain rounds
    bus.wr_data_vc0 = 5'h15; bus.wr_en_vc0 = 1'b1;
    exp_q.push_back(6'h15);
    tick();
    clear_inputs();
    for (int i = 0; i < 3; i++) tick();
    for (int r = 0; r < 3; r++) begin
      bus.pause_vc0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
        bus.wr_en_vc0   = 1'b1;
        bus.wr_data_vc0 = 5'(r * 7 + i * 3 + 2);
        exp_q.push_back({1'b0, 5'(r * 7 + i * 3 + 2)});
        tick();
      end
      chk("wrap_full", bus.full_vc0, 1);
      clear_inputs();
      bus.continue_vc0 = 1'b1;
      tick();
      bus.continue_vc0 = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("wrap_idle", bus.idle, 1);
    end
    chk("wrap_no_err", bus.err, 0);

    chk("sb_drained_end", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
